// File: rtl/y86_decode_wb_pkg.sv
// Shared Y86-64 constants: instruction codes and special register IDs.
// Also used by the fetch and execute stages.
package y86_decode_wb_pkg;

  localparam logic [3:0] IHalt  = 4'h0;
  localparam logic [3:0] INop   = 4'h1;
  localparam logic [3:0] ICmov  = 4'h2;
  localparam logic [3:0] IIrmov = 4'h3;
  localparam logic [3:0] IRmmov = 4'h4;
  localparam logic [3:0] IMrmov = 4'h5;
  localparam logic [3:0] IOpq   = 4'h6;
  localparam logic [3:0] IJxx   = 4'h7;
  localparam logic [3:0] ICall  = 4'h8;
  localparam logic [3:0] IRet   = 4'h9;
  localparam logic [3:0] IPush  = 4'hA;
  localparam logic [3:0] IPop   = 4'hB;

  localparam logic [3:0] RegRsp  = 4'h4;
  localparam logic [3:0] RegNone = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// 15-entry program register file: two read ports, two write ports, one debug read port.
// ID 15 reads as zero and discards writes; the M port wins when both ports target one register.
module y86_regfile
  import y86_decode_wb_pkg::*;
#(
  parameter int unsigned   N        = 64,
  parameter logic [N-1:0]  RSP_INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   rd_a_sel,
  input  logic [3:0]   rd_b_sel,
  input  logic [3:0]   dbg_sel,
  output logic [N-1:0] rd_a_val,
  output logic [N-1:0] rd_b_val,
  output logic [N-1:0] dbg_val,
  input  logic         wr_en,
  input  logic [3:0]   wr_e_sel,
  input  logic [N-1:0] wr_e_val,
  input  logic [3:0]   wr_m_sel,
  input  logic [N-1:0] wr_m_val
);

  logic [N-1:0] regs_q [15];

  assign rd_a_val = (rd_a_sel == RegNone) ? '0 : regs_q[rd_a_sel];
  assign rd_b_val = (rd_b_sel == RegNone) ? '0 : regs_q[rd_b_sel];
  assign dbg_val  = (dbg_sel == RegNone)  ? '0 : regs_q[dbg_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == int'(RegRsp)) ? RSP_INIT : '0;
      end
    end else if (wr_en) begin
      if (wr_e_sel != RegNone) regs_q[wr_e_sel] <= wr_e_val;
      // Later assignment takes priority, so valM wins on dstE == dstM.
      if (wr_m_sel != RegNone) regs_q[wr_m_sel] <= wr_m_val;
    end
  end

endmodule

// File: rtl/y86_decode_wb.sv
// SEQ Y86-64 decode/write-back stage: selects register IDs from icode/rA/rB,
// reads operands combinationally and writes valE/valM back on the clock edge.
module y86_decode_wb
  import y86_decode_wb_pkg::*;
#(
  parameter int unsigned  N        = 64,
  parameter logic [N-1:0] RSP_INIT = 64'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [3:0]   rA,
  input  logic [3:0]   rB,
  input  logic [N-1:0] valE,
  input  logic [N-1:0] valM,
  input  logic         cnd,
  input  logic         wb_en,
  output logic [N-1:0] valA,
  output logic [N-1:0] valB,
  output logic [3:0]   srcA,
  output logic [3:0]   srcB,
  output logic [3:0]   dstE,
  output logic [3:0]   dstM,
  input  logic [3:0]   dbg_sel,
  output logic [N-1:0] dbg_val
);

  // ifun is reserved; selection does not depend on it.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  always_comb begin
    srcA = RegNone;
    srcB = RegNone;
    dstE = RegNone;
    dstM = RegNone;
    case (icode)
      ICmov: begin
        srcA = rA;
        dstE = cnd ? rB : RegNone;
      end
      IIrmov: dstE = rB;
      IRmmov: begin
        srcA = rA;
        srcB = rB;
      end
      IMrmov: begin
        srcB = rB;
        dstM = rA;
      end
      IOpq: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      ICall: begin
        srcB = RegRsp;
        dstE = RegRsp;
      end
      IRet: begin
        srcA = RegRsp;
        srcB = RegRsp;
        dstE = RegRsp;
      end
      IPush: begin
        srcA = rA;
        srcB = RegRsp;
        dstE = RegRsp;
      end
      IPop: begin
        srcA = RegRsp;
        srcB = RegRsp;
        dstE = RegRsp;
        dstM = rA;
      end
      default: ;
    endcase
  end

  y86_regfile #(
    .N        (N),
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rd_a_sel (srcA),
    .rd_b_sel (srcB),
    .dbg_sel  (dbg_sel),
    .rd_a_val (valA),
    .rd_b_val (valB),
    .dbg_val  (dbg_val),
    .wr_en    (wb_en),
    .wr_e_sel (dstE),
    .wr_e_val (valE),
    .wr_m_sel (dstM),
    .wr_m_val (valM)
  );

endmodule

// File: tb/tb_y86_decode_wb.sv
// Scoreboard bench for y86_decode_wb: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_y86_decode_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  icode, ifun, rA, rB, dbg_sel;
  logic [63:0] valE, valM;
  logic        cnd, wb_en;
  logic [63:0] valA, valB, dbg_val;
  logic [3:0]  srcA, srcB, dstE, dstM;

  always #5 clk = ~clk;

  y86_decode_wb #(
    .N        (64),
    .RSP_INIT (64'h100)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .icode   (icode),
    .ifun    (ifun),
    .rA      (rA),
    .rB      (rB),
    .valE    (valE),
    .valM    (valM),
    .cnd     (cnd),
    .wb_en   (wb_en),
    .valA    (valA),
    .valB    (valB),
    .srcA    (srcA),
    .srcB    (srcB),
    .dstE    (dstE),
    .dstM    (dstM),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

  typedef enum int {SigValA, SigValB, SigSrcA, SigSrcB, SigDstE, SigDstM, SigDbg} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string name, input sig_e sig, input logic [63:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the write edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.sig)
        SigValA: act = valA;
        SigValB: act = valB;
        SigSrcA: act = {60'd0, srcA};
        SigSrcB: act = {60'd0, srcB};
        SigDstE: act = {60'd0, dstE};
        SigDstM: act = {60'd0, dstM};
        default: act = dbg_val;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic dbg_check(input string name, input logic [3:0] sel, input logic [63:0] exp);
    icode   = 4'h1;
    wb_en   = 1'b0;
    dbg_sel = sel;
    expect_val(name, SigDbg, exp);
    step();
  endtask

  initial begin
    reset = 1'b1; icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
    valE = '0; valM = '0; cnd = 1'b0; wb_en = 1'b0; dbg_sel = 4'hF;
    step();
    step();
    reset = 1'b0;

    // Reset state
    expect_val("reset_srcA", SigSrcA, 64'hF);
    expect_val("reset_valA", SigValA, 64'h0);
    expect_val("reset_valB", SigValB, 64'h0);
    for (int i = 0; i < 16; i++) begin
      dbg_check($sformatf("reset_R%0d", i), i[3:0], (i == 4) ? 64'h100 : 64'h0);
    end

    // irmovq -> R2, same-cycle read returns old value
    icode = 4'h3; rA = 4'hF; rB = 4'h2; valE = 64'h1234; wb_en = 1'b1; dbg_sel = 4'h2;
    expect_val("irmov_dstE", SigDstE, 64'h2);
    expect_val("irmov_srcA", SigSrcA, 64'hF);
    expect_val("irmov_srcB", SigSrcB, 64'hF);
    expect_val("irmov_dstM", SigDstM, 64'hF);
    expect_val("irmov_old", SigDbg, 64'h0);
    step();
    dbg_check("irmov_R2", 4'h2, 64'h1234);

    // cmovle not taken, then taken
    icode = 4'h2; rA = 4'h2; rB = 4'h3; cnd = 1'b0; valE = 64'h9999; wb_en = 1'b1;
    expect_val("cmov0_dstE", SigDstE, 64'hF);
    expect_val("cmov0_srcA", SigSrcA, 64'h2);
    expect_val("cmov0_valA", SigValA, 64'h1234);
    expect_val("cmov0_srcB", SigSrcB, 64'hF);
    step();
    dbg_check("cmov0_R3", 4'h3, 64'h0);
    icode = 4'h2; rA = 4'h2; rB = 4'h3; cnd = 1'b1; valE = 64'h1234; wb_en = 1'b1;
    expect_val("cmov1_dstE", SigDstE, 64'h3);
    step();
    cnd = 1'b0;
    dbg_check("cmov1_R3", 4'h3, 64'h1234);

    // mrmovq: dstM=rA, srcB=rB
    icode = 4'h5; rA = 4'h6; rB = 4'h2; valM = 64'hABCD; valE = 64'h1; wb_en = 1'b1;
    expect_val("mrmov_srcA", SigSrcA, 64'hF);
    expect_val("mrmov_srcB", SigSrcB, 64'h2);
    expect_val("mrmov_dstE", SigDstE, 64'hF);
    expect_val("mrmov_dstM", SigDstM, 64'h6);
    step();
    dbg_check("mrmov_R6", 4'h6, 64'hABCD);

    // popq %rsp: valM wins over valE
    icode = 4'hB; rA = 4'h4; rB = 4'hF; valE = 64'h108; valM = 64'hBEEF; wb_en = 1'b1;
    expect_val("pop_srcA", SigSrcA, 64'h4);
    expect_val("pop_srcB", SigSrcB, 64'h4);
    expect_val("pop_dstE", SigDstE, 64'h4);
    expect_val("pop_dstM", SigDstM, 64'h4);
    expect_val("pop_valA", SigValA, 64'h100);
    step();
    dbg_check("pop_R4", 4'h4, 64'hBEEF);

    // jxx (unused icode): no IDs, no write
    icode = 4'h7; rA = 4'h1; rB = 4'h2; valE = 64'hDEAD; valM = 64'hDEAD; wb_en = 1'b1;
    expect_val("jxx_srcA", SigSrcA, 64'hF);
    expect_val("jxx_dstE", SigDstE, 64'hF);
    expect_val("jxx_dstM", SigDstM, 64'hF);
    step();
    dbg_check("jxx_R2", 4'h2, 64'h1234);

    // opq with wb_en=0 then 1
    icode = 4'h6; rA = 4'h1; rB = 4'h2; valE = 64'h55; wb_en = 1'b0;
    expect_val("opq_srcA", SigSrcA, 64'h1);
    expect_val("opq_srcB", SigSrcB, 64'h2);
    expect_val("opq_dstE", SigDstE, 64'h2);
    expect_val("opq_valA", SigValA, 64'h0);
    expect_val("opq_valB", SigValB, 64'h1234);
    step();
    dbg_check("opq_nowb_R2", 4'h2, 64'h1234);
    icode = 4'h6; rA = 4'h1; rB = 4'h2; valE = 64'h55; wb_en = 1'b1;
    step();
    dbg_check("opq_wb_R2", 4'h2, 64'h55);

    // reset overrides a simultaneous write
    icode = 4'h6; rA = 4'h1; rB = 4'h2; valE = 64'h77; wb_en = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    dbg_check("rst_R2", 4'h2, 64'h0);
    dbg_check("rst_R4", 4'h4, 64'h100);
    dbg_check("rst_R6", 4'h6, 64'h0);

    // pushq %rsp
    icode = 4'hA; rA = 4'h4; rB = 4'hF; valE = 64'hF8; wb_en = 1'b1;
    expect_val("push_valA", SigValA, 64'h100);
    expect_val("push_valB", SigValB, 64'h100);
    expect_val("push_dstE", SigDstE, 64'h4);
    expect_val("push_dstM", SigDstM, 64'hF);
    step();
    dbg_check("push_R4", 4'h4, 64'hF8);

    // call / ret IDs
    icode = 4'h8; rA = 4'hF; rB = 4'hF; wb_en = 1'b0;
    expect_val("call_srcA", SigSrcA, 64'hF);
    expect_val("call_srcB", SigSrcB, 64'h4);
    expect_val("call_dstE", SigDstE, 64'h4);
    step();
    icode = 4'h9;
    expect_val("ret_srcA", SigSrcA, 64'h4);
    expect_val("ret_dstE", SigDstE, 64'h4);
    expect_val("ret_dstM", SigDstM, 64'hF);
    step();

    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
